// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0, MSB first; busy for 17*CLK_DIV cycles per transfer.
// Outputs are registered from next-state decode, so there is no input-to-output combinational path.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state, state_nxt;
  logic       start_d;
  logic [7:0] div_cnt, div_cnt_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] tx_sr, tx_sr_nxt;
  logic [7:0] rx_sr, rx_sr_nxt;
  logic [7:0] data_out_nxt;
  logic       done_nxt;
  logic       phase_end;

  assign phase_end = (div_cnt == DIV_LAST);

  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt + 8'd1;
    bit_cnt_nxt  = bit_cnt;
    tx_sr_nxt    = tx_sr;
    rx_sr_nxt    = rx_sr;
    data_out_nxt = data_out;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        div_cnt_nxt = 8'd0;
        if (start && !start_d) begin
          tx_sr_nxt   = data_in;
          bit_cnt_nxt = 3'd7;
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        if (phase_end) begin
          div_cnt_nxt = 8'd0;
          rx_sr_nxt   = {rx_sr[6:0], miso};
          state_nxt   = HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          div_cnt_nxt = 8'd0;
          if (bit_cnt == 3'd0) begin
            state_nxt = HOLD;
          end else begin
            // Shift on entry to LOW so mosi changes on the falling SCLK edge
            tx_sr_nxt   = {tx_sr[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt - 3'd1;
            state_nxt   = LOW;
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          div_cnt_nxt = 8'd0;
          rx_sr_nxt   = {rx_sr[6:0], miso};
          state_nxt   = HIGH;
        end
      end
      HOLD: begin
        if (phase_end) begin
          div_cnt_nxt  = 8'd0;
          data_out_nxt = rx_sr;
          done_nxt     = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: begin
        div_cnt_nxt = 8'd0;
        state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state    <= IDLE;
      start_d  <= 1'b1;
      div_cnt  <= 8'd0;
      bit_cnt  <= 3'd0;
      tx_sr    <= 8'd0;
      rx_sr    <= 8'd0;
      data_out <= 8'd0;
      done     <= 1'b0;
      busy     <= 1'b0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      state    <= state_nxt;
      start_d  <= start;
      div_cnt  <= div_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tx_sr    <= tx_sr_nxt;
      rx_sr    <= rx_sr_nxt;
      data_out <= data_out_nxt;
      done     <= done_nxt;
      busy     <= (state_nxt != IDLE);
      cs_n     <= (state_nxt == IDLE);
      sclk     <= (state_nxt == HIGH);
      mosi     <= (state_nxt == IDLE) ? 1'b0 : tx_sr_nxt[7];
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance at CLK_DIV=4 and one at CLK_DIV=1.
module tb_spi_master;

  logic       raw_clk = 1'b0;
  logic       reset;
  logic       start4, start1;
  logic [7:0] din4, din1, dout4, dout1;
  logic       busy4, busy1, done4, done1, sclk4, sclk1;
  logic       mosi4, mosi1, miso4, miso1, cs4, cs1;
  logic       loop4, mconst;

  int passed = 0;
  int total  = 0;

  // Results of the last watch() window
  int         busy_cyc, hi_cyc, rises, done_cnt, idle_mosi, first_rise;
  logic [7:0] mosi_bits;
  logic       first_busy, first_cs, first_mosi;

  always #5 raw_clk = ~raw_clk;

  assign miso4 = loop4 ? mosi4 : mconst;
  assign miso1 = mosi1;

  spi_master #(.CLK_DIV(4)) dut4 (
    .raw_clk(raw_clk), .reset(reset), .start(start4), .data_in(din4),
    .data_out(dout4), .busy(busy4), .done(done4), .sclk(sclk4),
    .mosi(mosi4), .miso(miso4), .cs_n(cs4)
  );

  spi_master #(.CLK_DIV(1)) dut1 (
    .raw_clk(raw_clk), .reset(reset), .start(start1), .data_in(din1),
    .data_out(dout1), .busy(busy1), .done(done1), .sclk(sclk1),
    .mosi(mosi1), .miso(miso1), .cs_n(cs1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start1 = v;
    else     start4 = v;
  endtask

  // Produce a fresh rising edge on start with the given TX byte
  task automatic kick(input bit sel, input logic [7:0] d);
    @(negedge raw_clk);
    set_start(sel, 1'b0);
    @(negedge raw_clk);
    if (sel) din1 = d;
    else     din4 = d;
    set_start(sel, 1'b1);
  endtask

  task automatic watch(input bit sel, input int ncyc, input int retrig_at, input logic [7:0] retrig_data);
    logic b, c, m, s, d, prev;
    busy_cyc = 0; hi_cyc = 0; rises = 0; done_cnt = 0; idle_mosi = 0;
    first_rise = -1; mosi_bits = 8'h00; prev = 1'b0;
    first_busy = 1'b0; first_cs = 1'b1; first_mosi = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge raw_clk);
      b = sel ? busy1 : busy4;
      c = sel ? cs1   : cs4;
      m = sel ? mosi1 : mosi4;
      s = sel ? sclk1 : sclk4;
      d = sel ? done1 : done4;
      if (i == 0) begin
        first_busy = b; first_cs = c; first_mosi = m;
      end
      if (b) busy_cyc++;
      if (s) hi_cyc++;
      if (s && !prev) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], m};
        if (first_rise < 0) first_rise = i;
      end
      if (d) done_cnt++;
      if (!b && m) idle_mosi++;
      prev = s;
      if (i == retrig_at - 1) set_start(sel, 1'b0);
      if (i == retrig_at) begin
        set_start(sel, 1'b1);
        if (sel) din1 = retrig_data;
        else     din4 = retrig_data;
      end
    end
  endtask

  initial begin
    int dn;
    reset = 1'b1; start4 = 1'b1; start1 = 1'b1;
    din4 = 8'h00; din1 = 8'h00; loop4 = 1'b1; mconst = 1'b0;

    // Reset with start held high
    repeat (3) @(posedge raw_clk);
    @(negedge raw_clk);
    chk("rst_cs_n", cs4, 1);
    chk("rst_sclk", sclk4, 0);
    chk("rst_mosi", mosi4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_dout", dout4, 8'h00);
    reset = 1'b0;
    watch(0, 20, -1, 8'h00);
    chk("no_xfer_after_rst", busy_cyc, 0);
    chk("no_done_after_rst", done_cnt, 0);

    // Loopback 0xA5, CLK_DIV=4
    kick(0, 8'hA5);
    watch(0, 90, -1, 8'h00);
    chk("a5_first_busy", first_busy, 1);
    chk("a5_first_cs_n", first_cs, 0);
    chk("a5_first_mosi", first_mosi, 1);
    chk("a5_busy_cyc", busy_cyc, 68);
    chk("a5_rises", rises, 8);
    chk("a5_first_rise", first_rise, 4);
    chk("a5_hi_cyc", hi_cyc, 32);
    chk("a5_mosi_bits", mosi_bits, 8'hA5);
    chk("a5_done_cnt", done_cnt, 1);
    chk("a5_idle_mosi", idle_mosi, 0);
    chk("a5_dout", dout4, 8'hA5);

    // Constant MISO
    loop4 = 1'b0; mconst = 1'b1;
    kick(0, 8'h00);
    watch(0, 90, -1, 8'h00);
    chk("m1_mosi_bits", mosi_bits, 8'h00);
    chk("m1_dout", dout4, 8'hFF);
    mconst = 1'b0;
    kick(0, 8'hFF);
    watch(0, 90, -1, 8'h00);
    chk("m0_mosi_bits", mosi_bits, 8'hFF);
    chk("m0_dout", dout4, 8'h00);
    chk("m0_done_cnt", done_cnt, 1);

    // Start held high for 100 cycles
    loop4 = 1'b1;
    kick(0, 8'h5A);
    watch(0, 100, -1, 8'h00);
    chk("hold_done_cnt", done_cnt, 1);
    chk("hold_busy_cyc", busy_cyc, 68);
    chk("hold_dout", dout4, 8'h5A);

    // New start edge at cycle 20 is discarded
    kick(0, 8'hC3);
    watch(0, 100, 20, 8'h0F);
    chk("retrig_done_cnt", done_cnt, 1);
    chk("retrig_busy_cyc", busy_cyc, 68);
    chk("retrig_dout", dout4, 8'hC3);

    // Reset at cycle 30 of a transfer
    kick(0, 8'h77);
    dn = 0;
    repeat (30) begin
      @(negedge raw_clk);
      if (done4) dn++;
    end
    chk("midrst_busy_before", busy4, 1);
    reset = 1'b1;
    @(negedge raw_clk);
    chk("midrst_cs_n", cs4, 1);
    chk("midrst_sclk", sclk4, 0);
    chk("midrst_mosi", mosi4, 0);
    chk("midrst_busy", busy4, 0);
    chk("midrst_done", done4, 0);
    chk("midrst_dout", dout4, 8'h00);
    reset = 1'b0;
    watch(0, 10, -1, 8'h00);
    chk("midrst_no_done", dn + done_cnt, 0);
    chk("midrst_no_xfer", busy_cyc, 0);
    kick(0, 8'h3C);
    watch(0, 90, -1, 8'h00);
    chk("post_rst_done_cnt", done_cnt, 1);
    chk("post_rst_busy_cyc", busy_cyc, 68);
    chk("post_rst_dout", dout4, 8'h3C);

    // CLK_DIV=1 loopback 0x81
    kick(1, 8'h81);
    watch(1, 30, -1, 8'h00);
    chk("d1_busy_cyc", busy_cyc, 17);
    chk("d1_rises", rises, 8);
    chk("d1_hi_cyc", hi_cyc, 8);
    chk("d1_first_rise", first_rise, 1);
    chk("d1_mosi_bits", mosi_bits, 8'h81);
    chk("d1_done_cnt", done_cnt, 1);
    chk("d1_dout", dout1, 8'h81);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, running in the raw_clk domain. It sits directly downstream of the memory-mapped peripheral register block. That block drives it with a start strobe and a TX byte, and reads back the busy flag and the RX byte. The block sequences chip select, SCLK, MOSI shifting and MISO sampling, and reports completion with a one-cycle done pulse.

## Interface
- CLK_DIV, default 4: SCLK half-period in raw_clk cycles; legal range 1..255.
- raw_clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset reset, synchronous, active-high; clock raw_clk.
- start  input  1  transfer request; level from the slower clk domain; rising edge triggers.
- data_in  input  8  TX byte; sampled on the accepting edge only.
- data_out  output  8  last received byte; reset 0x00.
- busy  output  1  high from acceptance until return to IDLE; reset 0.
- done  output  1  one-cycle pulse at end of transfer; reset 0.
- sclk  output  1  SPI clock; idles low; reset 0.
- mosi  output  1  SPI data out; reset 0; driven 0 in IDLE.
- miso  input  1  SPI data in.
- cs_n  output  1  chip select, active-low; reset 1.

## Operation
- Edge detect: the start_d register samples start every cycle.
  - An accept condition is start=1, start_d=0, state IDLE.
  - start_d resets to 1, so start held high across reset release does not trigger a transfer.
- A rising edge seen outside IDLE is discarded. There is no queuing, and a later edge is required.
- Counter: half-period counter div_cnt, width 8, counts 0..CLK_DIV-1. A phase ends when div_cnt==CLK_DIV-1, and div_cnt then clears to 0.
- Bit counter bit_cnt, 3 bits, counts 7 down to 0.
- State machine:
  - IDLE: cs_n=1, sclk=0, mosi=0, busy=0. On accept: tx_sr<=data_in, bit_cnt<=7, div_cnt<=0, go to SETUP.
  - SETUP: cs_n=0, sclk=0, mosi=tx_sr[7]. At phase end, rx_sr<={rx_sr[6:0],miso} and go to HIGH.
  - HIGH: sclk=1. At phase end, go to LOW. If bit_cnt==0, go to HOLD instead.
  - LOW: sclk=0. On entry, tx_sr shifts left, so mosi presents the next bit. bit_cnt decrements on entry. At phase end, sample miso into rx_sr and go to HIGH.
  - HOLD: sclk=0, cs_n=0, mosi holds its last bit. At phase end: data_out<=rx_sr, done=1 for one cycle, go to IDLE.
- MISO sampling happens on the raw_clk edge that raises SCLK, so there are exactly 8 samples per transfer.
- data_out changes only when done pulses. It holds its value across later idle periods and across ignored starts.
- Reset mid-transfer aborts the transfer. On the next edge: IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, data_out=0x00. No done pulse is emitted.

## Timing
- Let cycle A be the accepting edge. From A+1:
  - busy=1, cs_n=0, mosi=data_in[7].
- SETUP lasts CLK_DIV cycles.
- 8 HIGH phases and 7 LOW phases of CLK_DIV cycles each.
- HOLD lasts CLK_DIV cycles.
- Total busy time is 17×CLK_DIV cycles: 68 for CLK_DIV=4, 17 for CLK_DIV=1.
- done=1 and data_out updated in the first IDLE cycle. busy=0 and cs_n=1 in that same cycle.
- Earliest next accept is the cycle after done, provided start has gone low and high again.
- SCLK frequency is raw_clk/(2×CLK_DIV). The first SCLK rise is CLK_DIV cycles after cs_n falls.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: assert reset for 3 cycles with start=1. Required: cs_n=1, sclk=0, mosi=0, busy=0, done=0, data_out=0x00. No transfer after reset release until start toggles low then high.
- Loopback, CLK_DIV=4: tie miso to mosi, data_in=0xA5, pulse start. Required:
  - busy high for exactly 68 cycles; 8 SCLK rising edges.
  - MOSI bits 1,0,1,0,0,1,0,1 at the rises.
  - done pulse 1 cycle; data_out=0xA5.
- Constant MISO: miso=1 with data_in=0x00 gives data_out=0xFF. Then miso=0 with data_in=0xFF gives data_out=0x00. MOSI matches data_in at every SCLK rise.
- Start handling:
  - Hold start high for 100 cycles: exactly one transfer.
  - A new start edge at cycle 20 of a transfer: ignored, one done only, data_out unchanged by data_in at that time.
- Reset at cycle 30 of a transfer: next cycle is IDLE with reset values, no done pulse. A following start with data_in=0x3C under loopback completes normally with data_out=0x3C.
- CLK_DIV=1: loopback 0x81 gives busy for exactly 17 cycles, SCLK high and low one cycle each, data_out=0x81.
